// File: rtl/rvb_clmul_seq.sv
// rvb_clmul_seq: multi-cycle carry-less multiplier for CLMUL / CLMULH / CLMULR.
// Retires BITS_PER_CYCLE multiplier bits per clock into a 64-bit accumulator,
// with a valid/ready handshake on both sides. A kill (pipeline flush) or a
// synchronous reset aborts the operation and returns the engine to IDLE.
// Optional feature macro: RVB_CLMUL_EARLY_EXIT_EN ends RUN as soon as the
// remaining multiplier bits are all zero.
module rvb_clmul_seq #(
   parameter int BITS_PER_CYCLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        kill,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  op,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        busy
);

   localparam int N = 32 / BITS_PER_CYCLE;
   localparam logic [5:0] CNT_LAST = 6'(N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] OP_CLMUL  = 2'b01;
   localparam logic [1:0] OP_CLMULH = 2'b11;
   localparam logic [1:0] OP_CLMULR = 2'b10;

   logic [1:0]  state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [63:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] res_q, res_d;
   logic        accept_s;
   logic        last_s;

   // One RUN step: xor in the shifted multiplicand for each set low multiplier bit.
   function automatic logic [63:0] acc_step(input logic [63:0] acc,
                                            input logic [63:0] a,
                                            input logic [31:0] b);
      logic [63:0] r;
      r = acc;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
         if (b[j]) begin
            r = r ^ (a << j);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Pick the 32-bit result window for the latched operation.
   function automatic logic [31:0] result_sel(input logic [1:0] o,
                                              input logic [63:0] acc);
      logic [31:0] r;
      case (o)
         OP_CLMUL:  r = acc[31:0];
         OP_CLMULH: r = acc[63:32];
         OP_CLMULR: r = acc[62:31];
         default:   r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   assign in_ready  = (state_q == ST_IDLE) & ~rst;
   assign out_valid = (state_q == ST_DONE) & ~rst;
   assign busy      = (state_q != ST_IDLE) & ~rst;
   assign out_result = res_q;

   assign accept_s = in_valid & in_ready & ~kill;

   // Next-state and datapath update; kill overrides every transition.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      last_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_RUN;
               op_d    = op;
               a_d     = {32'h0000_0000, rs1};
               b_d     = rs2;
               acc_d   = 64'h0;
               cnt_d   = 6'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d = acc_step(acc_q, a_q, b_q);
            a_d   = a_q << BITS_PER_CYCLE;
            b_d   = b_q >> BITS_PER_CYCLE;
            cnt_d = cnt_q + 6'd1;
`ifdef RVB_CLMUL_EARLY_EXIT_EN
            last_s = (cnt_q == CNT_LAST) | (b_d == 32'h0000_0000);
`else
            last_s = (cnt_q == CNT_LAST);
`endif
            if (last_s) begin
               state_d = ST_DONE;
               res_d   = result_sel(op_q, acc_d);
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (kill) begin
         // Aborted transaction: no result is published.
         state_d = ST_IDLE;
         res_d   = res_q;
      end else begin
         state_d = state_d;
      end
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= 2'b00;
         a_q     <= 64'h0;
         b_q     <= 32'h0000_0000;
         acc_q   <= 64'h0;
         cnt_q   <= 6'd0;
         res_q   <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

endmodule
